mem_bank: RTL and testbench

//  Parametrised successor to the single-port data memory: a simple dual-port RAM

---
 rtl/mem_bank_if.sv | 26 ++
 rtl/mem_bank.sv | 118 +++++++++++
 tb/tb_mem_bank.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_bank_if.sv
// Request/response bundle for mem_bank: clear pulse, write port, read port and status.
// The master drives requests and the slave (the memory) returns read data and busy.
interface mem_bank_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) ();
  logic              clr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;

  modport master (
    output clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/mem_bank.sv
// Simple dual-port RAM with a pipelined read (latency 1 or 2), optional
// write-to-read bypass on address collision, and a word-per-cycle clear engine.
module mem_bank #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 2**ADDR_W,
  parameter int unsigned RD_LAT = 1,
  parameter bit          BYPASS = 1'b1
) (
  input logic       clk,
  input logic       rst,
  mem_bank_if.slave bus
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              busy_q, busy_d;
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              idle_ops;
  logic              wr_ok;
  logic              rd_accept;
  logic              rd_in_range;
  logic [DATA_W-1:0] rd_word;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [DATA_W-1:0] mem_wdata;

  // A clear request in IDLE takes priority over any same-cycle read or write.
  always_comb begin
    idle_ops    = (state_q == IDLE) && !bus.clr;
    wr_ok       = idle_ops && bus.wr_en && (32'(bus.wr_addr) < DEPTH);
    rd_accept   = idle_ops && bus.rd_en;
    rd_in_range = 32'(bus.rd_addr) < DEPTH;

    rd_word = '0;
    if (rd_in_range) begin
      if (BYPASS && wr_ok && (bus.wr_addr == bus.rd_addr)) begin
        rd_word = bus.wr_data;
      end else begin
        rd_word = mem_q[bus.rd_addr[IDX_W-1:0]];
      end
    end

    mem_we    = (state_q == CLEAR) || wr_ok;
    mem_widx  = (state_q == CLEAR) ? clr_ptr_q[IDX_W-1:0] : bus.wr_addr[IDX_W-1:0];
    mem_wdata = (state_q == CLEAR) ? '0 : bus.wr_data;
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == CLEAR) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (32'(clr_ptr_q) == DEPTH - 1) begin
        state_d = IDLE;
      end
    end else if (bus.clr) begin
      state_d   = CLEAR;
      clr_ptr_d = '0;
    end
    busy_d = (state_d == CLEAR);

    s1_valid_d = rd_accept;
    s1_data_d  = rd_accept ? rd_word : s1_data_q;

    // Reads already in the pipeline drain even if a clear has started.
    if (RD_LAT == 2) begin
      out_valid = s1_valid_q;
      out_data  = s1_data_q;
    end else begin
      out_valid = rd_accept;
      out_data  = rd_word;
    end
    rd_valid_d = out_valid;
    rd_data_d  = out_valid ? out_data : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= CLEAR;
      clr_ptr_q  <= '0;
      busy_q     <= 1'b1;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      busy_q     <= busy_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_mem_bank.sv
// Drives two mem_bank configurations with identical stimulus and checks every
// cycle against a per-instance reference model (array + pending-read queue).
module tb_mem_bank;
  localparam int N = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_addr = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_bank_if #(.DATA_W(8), .ADDR_W(8)) ifa ();
  mem_bank_if #(.DATA_W(8), .ADDR_W(8)) ifb ();

  assign ifa.clr = clr;     assign ifb.clr = clr;
  assign ifa.wr_en = wr_en; assign ifb.wr_en = wr_en;
  assign ifa.wr_addr = wr_addr; assign ifb.wr_addr = wr_addr;
  assign ifa.wr_data = wr_data; assign ifb.wr_data = wr_data;
  assign ifa.rd_en = rd_en; assign ifb.rd_en = rd_en;
  assign ifa.rd_addr = rd_addr; assign ifb.rd_addr = rd_addr;

  mem_bank #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .RD_LAT(2), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );
  mem_bank #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .RD_LAT(1), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  function automatic int depth_of(input int k);
    return (k == 0) ? 200 : 256;
  endfunction
  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction
  function automatic bit byp_of(input int k);
    return (k == 0);
  endfunction

  // Reference model
  typedef struct {
    int         dut;
    logic [7:0] val;
    longint     due;
  } rd_t;

  logic [7:0] m_mem [N][256];
  int         busy_left [N];
  rd_t        pend [$];
  longint     cyc = 0;
  logic       exp_valid [N];
  logic [7:0] exp_data [N];
  logic       exp_busy [N];

  task automatic model_edge();
    logic [7:0] v;
    int         hit;
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (!rst) begin
        busy_left[k] = depth_of(k);
        for (int a = 0; a < 256; a++) m_mem[k][a] = '0;
        for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].dut == k) pend.delete(i);
        exp_data[k] = '0;
      end else if (busy_left[k] > 0) begin
        busy_left[k]--;
      end else if (clr) begin
        busy_left[k] = depth_of(k);
        for (int a = 0; a < 256; a++) m_mem[k][a] = '0;
      end else begin
        if (rd_en) begin
          if (int'(rd_addr) >= depth_of(k)) v = '0;
          else if (byp_of(k) && wr_en && wr_addr == rd_addr) v = wr_data;
          else v = m_mem[k][rd_addr];
          pend.push_back('{k, v, cyc + longint'(lat_of(k)) - 1});
        end
        if (wr_en && int'(wr_addr) < depth_of(k)) m_mem[k][wr_addr] = wr_data;
      end
      exp_busy[k]  = (busy_left[k] > 0);
      exp_valid[k] = 1'b0;
      hit = -1;
      for (int i = 0; i < pend.size(); i++) begin
        if (hit < 0 && pend[i].dut == k && pend[i].due == cyc) hit = i;
      end
      if (hit >= 0) begin
        exp_valid[k] = 1'b1;
        exp_data[k]  = pend[hit].val;
        pend.delete(hit);
      end
    end
  endtask

  task automatic check_outputs();
    logic       o_valid [N];
    logic [7:0] o_data [N];
    logic       o_busy [N];
    o_valid[0] = ifa.rd_valid; o_data[0] = ifa.rd_data; o_busy[0] = ifa.busy;
    o_valid[1] = ifb.rd_valid; o_data[1] = ifb.rd_data; o_busy[1] = ifb.busy;
    for (int k = 0; k < N; k++) begin
      tests++;
      assert (o_busy[k] === exp_busy[k]) else begin
        fails++;
        $error("FAIL busy[%0d] cyc %0d: observed %b expected %b", k, cyc, o_busy[k], exp_busy[k]);
      end
      tests++;
      assert (o_valid[k] === exp_valid[k]) else begin
        fails++;
        $error("FAIL rd_valid[%0d] cyc %0d: observed %b expected %b", k, cyc, o_valid[k], exp_valid[k]);
      end
      tests++;
      assert (o_data[k] === exp_data[k]) else begin
        fails++;
        $error("FAIL rd_data[%0d] cyc %0d: observed %h expected %h", k, cyc, o_data[k], exp_data[k]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic op(input logic r, input logic c, input logic we, input logic [7:0] wa,
                    input logic [7:0] wd, input logic re, input logic [7:0] ra);
    rst = r; clr = c; wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    for (int k = 0; k < N; k++) busy_left[k] = 0;

    // Reset and the full power-on clear, then a read of address 5
    op(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    idle(260);
    op(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'd5);
    idle(3);

    // Basic write then reads
    op(1'b1, 1'b0, 1'b1, 8'd0, 8'd69, 1'b0, 8'h00);
    op(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'd5);
    op(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'd0);
    idle(3);

    // Collision on address 3
    op(1'b1, 1'b0, 1'b1, 8'd3, 8'h11, 1'b0, 8'h00);
    op(1'b1, 1'b0, 1'b1, 8'd3, 8'hAA, 1'b1, 8'd3);
    op(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'd3);
    idle(3);

    // Streaming reads
    for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 1'b1, 8'(i), 8'(i + 1), 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'(i));
    idle(3);

    // Fill, clear with traffic and a second clr while busy, then read everything
    for (int i = 0; i < 256; i++) op(1'b1, 1'b0, 1'b1, 8'(i), 8'($urandom), 1'b0, 8'h00);
    op(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'd7);
    op(1'b1, 1'b1, 1'b1, 8'd9, 8'h55, 1'b1, 8'd9);
    for (int i = 0; i < 60; i++)
      op(1'b1, (i == 20), 1'b1, 8'($urandom), 8'($urandom), 1'b1, 8'($urandom));
    idle(200);
    for (int i = 0; i < 256; i++) op(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'(i));
    idle(3);

    // Reset mid-clear, reset with a read outstanding, out-of-range read
    op(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    idle(50);
    op(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    idle(260);
    op(1'b1, 1'b0, 1'b1, 8'd10, 8'h3C, 1'b1, 8'd10);
    op(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    idle(260);
    op(1'b1, 1'b0, 1'b1, 8'd250, 8'h77, 1'b1, 8'd250);
    op(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'd250);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] wa;
      wa = 8'($urandom);
      op(($urandom_range(0, 599) != 0), ($urandom_range(0, 399) == 0),
         1'($urandom), wa, 8'($urandom), 1'($urandom),
         ($urandom_range(0, 3) == 0) ? wa : 8'($urandom));
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
